// File: rtl/ifc_or_arbiter.sv
// Purpose : shares one single-bit OR unit between two request/response clients.
// Latency : req fire at edge N -> grant N+1 -> operands N+2 -> result N+3 (all rdy high).
// Backpr. : a client with an undrained result is skipped; shared-unit rdy stalls SEND/WAIT_Y.
//
// Ports:
//   CLK, RST               clock, synchronous active-high reset
//   cX_req_a/b/en, _rdy    per-client request slot (rdy = slot empty)
//   cX_resp_en/data/rdy    per-client response slot (rdy = result valid)
//   dut_a/b_data/en/rdy    operand methods towards the shared unit
//   dut_y_en/data/rdy      result method from the shared unit
module ifc_or_arbiter (
  input  logic CLK,
  input  logic RST,
  input  logic c0_req_a,
  input  logic c0_req_b,
  input  logic c0_req_en,
  output logic c0_req_rdy,
  input  logic c0_resp_en,
  output logic c0_resp_data,
  output logic c0_resp_rdy,
  input  logic c1_req_a,
  input  logic c1_req_b,
  input  logic c1_req_en,
  output logic c1_req_rdy,
  input  logic c1_resp_en,
  output logic c1_resp_data,
  output logic c1_resp_rdy,
  output logic dut_a_data,
  output logic dut_b_data,
  output logic dut_a_en,
  output logic dut_b_en,
  input  logic dut_a_rdy,
  input  logic dut_b_rdy,
  output logic dut_y_en,
  input  logic dut_y_data,
  input  logic dut_y_rdy
);

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_WAIT_Y} state_t;

  state_t     state_q;
  logic [1:0] req_vld_q, req_a_q, req_b_q;
  logic [1:0] resp_vld_q, resp_dat_q;
  logic       work_a_q, work_b_q;
  logic       owner_q, last_q;
  logic       a_sent_q, b_sent_q;

  logic [1:0] req_fire, req_a_in, req_b_in, resp_take, elig;
  logic       grant_vld, grant_id;
  logic       a_fire, b_fire, y_fire, a_done, b_done;

  assign req_fire  = {c1_req_en, c0_req_en};
  assign req_a_in  = {c1_req_a, c0_req_a};
  assign req_b_in  = {c1_req_b, c0_req_b};
  assign resp_take = {c1_resp_en, c0_resp_en};

  // Registered resp valid is used here, so a result drained this cycle only
  // makes its client eligible from the next cycle on.
  assign elig      = req_vld_q & ~resp_vld_q;
  assign grant_vld = (state_q == ST_IDLE) && (elig != 2'b00);
  // Tie goes to the client not granted last; otherwise the lone requester.
  assign grant_id  = (elig == 2'b11) ? ~last_q : elig[1];

  assign a_fire = (state_q == ST_SEND) && !a_sent_q && dut_a_rdy;
  assign b_fire = (state_q == ST_SEND) && !b_sent_q && dut_b_rdy;
  assign y_fire = (state_q == ST_WAIT_Y) && dut_y_rdy;
  assign a_done = a_sent_q || a_fire;
  assign b_done = b_sent_q || b_fire;

  assign dut_a_en   = a_fire;
  assign dut_b_en   = b_fire;
  assign dut_y_en   = y_fire;
  assign dut_a_data = (state_q == ST_SEND) ? work_a_q : 1'b0;
  assign dut_b_data = (state_q == ST_SEND) ? work_b_q : 1'b0;

  assign c0_req_rdy   = ~req_vld_q[0];
  assign c1_req_rdy   = ~req_vld_q[1];
  assign c0_resp_rdy  = resp_vld_q[0];
  assign c1_resp_rdy  = resp_vld_q[1];
  assign c0_resp_data = resp_dat_q[0];
  assign c1_resp_data = resp_dat_q[1];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      req_vld_q  <= 2'b00;
      req_a_q    <= 2'b00;
      req_b_q    <= 2'b00;
      resp_vld_q <= 2'b00;
      resp_dat_q <= 2'b00;
      work_a_q   <= 1'b0;
      work_b_q   <= 1'b0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      a_sent_q   <= 1'b0;
      b_sent_q   <= 1'b0;
    end else begin
      // A granted slot is freed here; a client cannot fire into it this
      // cycle because its rdy is still low, so the load below never collides.
      if (grant_vld) req_vld_q[grant_id] <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        if (req_fire[i]) begin
          req_vld_q[i] <= 1'b1;
          req_a_q[i]   <= req_a_in[i];
          req_b_q[i]   <= req_b_in[i];
        end
        if (resp_take[i]) resp_vld_q[i] <= 1'b0;
      end
      // The owner was eligible, so its response slot is empty here.
      if (y_fire) begin
        resp_vld_q[owner_q] <= 1'b1;
        resp_dat_q[owner_q] <= dut_y_data;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (grant_vld) begin
            work_a_q <= req_a_q[grant_id];
            work_b_q <= req_b_q[grant_id];
            owner_q  <= grant_id;
            last_q   <= grant_id;
            state_q  <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (a_done && b_done) begin
            a_sent_q <= 1'b0;
            b_sent_q <= 1'b0;
            state_q  <= ST_WAIT_Y;
          end else begin
            a_sent_q <= a_done;
            b_sent_q <= b_done;
          end
        end
        ST_WAIT_Y: begin
          if (y_fire) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifc_or_arbiter.sv
module tb_ifc_or_arbiter;

  logic CLK = 1'b0;
  logic RST;
  logic c0_req_a, c0_req_b, c0_req_en, c0_req_rdy, c0_resp_en, c0_resp_data, c0_resp_rdy;
  logic c1_req_a, c1_req_b, c1_req_en, c1_req_rdy, c1_resp_en, c1_resp_data, c1_resp_rdy;
  logic dut_a_data, dut_b_data, dut_a_en, dut_b_en, dut_a_rdy, dut_b_rdy;
  logic dut_y_en, dut_y_data, dut_y_rdy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  ifc_or_arbiter dut (
    .CLK(CLK), .RST(RST),
    .c0_req_a(c0_req_a), .c0_req_b(c0_req_b), .c0_req_en(c0_req_en), .c0_req_rdy(c0_req_rdy),
    .c0_resp_en(c0_resp_en), .c0_resp_data(c0_resp_data), .c0_resp_rdy(c0_resp_rdy),
    .c1_req_a(c1_req_a), .c1_req_b(c1_req_b), .c1_req_en(c1_req_en), .c1_req_rdy(c1_req_rdy),
    .c1_resp_en(c1_resp_en), .c1_resp_data(c1_resp_data), .c1_resp_rdy(c1_resp_rdy),
    .dut_a_data(dut_a_data), .dut_b_data(dut_b_data), .dut_a_en(dut_a_en), .dut_b_en(dut_b_en),
    .dut_a_rdy(dut_a_rdy), .dut_b_rdy(dut_b_rdy),
    .dut_y_en(dut_y_en), .dut_y_data(dut_y_data), .dut_y_rdy(dut_y_rdy)
  );

  // Shared OR unit: latches each operand when its method fires.
  logic ua = 1'b0, ub = 1'b0;
  always @(posedge CLK) begin
    if (dut_a_en) ua <= dut_a_data;
    if (dut_b_en) ub <= dut_b_data;
  end
  assign dut_y_data = ua | ub;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_c0_req_rdy"},  c0_req_rdy,  1);
    chk({tag, "_c1_req_rdy"},  c1_req_rdy,  1);
    chk({tag, "_c0_resp_rdy"}, c0_resp_rdy, 0);
    chk({tag, "_c1_resp_rdy"}, c1_resp_rdy, 0);
    chk({tag, "_c0_resp_dat"}, c0_resp_data, 0);
    chk({tag, "_c1_resp_dat"}, c1_resp_data, 0);
    chk({tag, "_ens"}, {dut_a_en, dut_b_en, dut_y_en}, 0);
    chk({tag, "_dut_data"}, {dut_a_data, dut_b_data}, 0);
  endtask

  initial begin
    bit q0[$];
    bit q1[$];
    int sent0, sent1, got0, got1;
    logic [7:0] exp;

    RST = 1'b1;
    {c0_req_a, c0_req_b, c0_req_en, c0_resp_en} = '0;
    {c1_req_a, c1_req_b, c1_req_en, c1_resp_en} = '0;
    dut_a_rdy = 1'b1; dut_b_rdy = 1'b1; dut_y_rdy = 1'b1;
    step(); step();
    RST = 1'b0;
    chk_reset_vals("reset");

    // Single request, c0 a=1 b=0
    c0_req_a = 1; c0_req_b = 0; c0_req_en = 1;
    step(); c0_req_en = 0;
    chk("single_req_rdy_low", c0_req_rdy, 0);
    chk("single_idle_ens", {dut_a_en, dut_b_en, dut_y_en}, 0);
    step();
    chk("single_send_ens", {dut_a_en, dut_b_en, dut_y_en}, 3'b110);
    chk("single_send_data", {dut_a_data, dut_b_data}, 2'b10);
    chk("single_slot_reenabled", c0_req_rdy, 1);
    step();
    chk("single_wait_ens", {dut_a_en, dut_b_en, dut_y_en}, 3'b001);
    chk("single_wait_data_zero", {dut_a_data, dut_b_data}, 0);
    chk("single_no_early_resp", c0_resp_rdy, 0);
    step();
    chk("single_resp", {c0_resp_rdy, c0_resp_data}, 2'b11);
    chk("single_c1_untouched", {c1_resp_rdy, c1_req_rdy}, 2'b01);
    c0_resp_en = 1; step(); c0_resp_en = 0;
    chk("single_drained", c0_resp_rdy, 0);

    // Tie after reset: c0 wins, then c1; next tie after c1 -> c0 first
    RST = 1; step(); RST = 0;
    c0_req_a = 0; c0_req_b = 0; c0_req_en = 1;
    c1_req_a = 1; c1_req_b = 1; c1_req_en = 1;
    step(); c0_req_en = 0; c1_req_en = 0;
    step();
    chk("tie1_grant_c0_data", {dut_a_data, dut_b_data, dut_a_en}, 3'b001);
    chk("tie1_c1_waiting", {c1_req_rdy, c0_req_rdy}, 2'b01);
    step(); step();
    chk("tie1_c0_resp", {c0_resp_rdy, c0_resp_data}, 2'b10);
    c0_resp_en = 1; step(); c0_resp_en = 0;
    chk("tie1_c0_drained", c0_resp_rdy, 0);
    chk("tie1_grant_c1_data", {dut_a_data, dut_b_data}, 2'b11);
    step(); step();
    chk("tie1_c1_resp", {c1_resp_rdy, c1_resp_data}, 2'b11);
    c1_resp_en = 1; step(); c1_resp_en = 0;
    c0_req_a = 1; c0_req_b = 0; c0_req_en = 1;
    c1_req_a = 0; c1_req_b = 0; c1_req_en = 1;
    step(); c0_req_en = 0; c1_req_en = 0;
    step();
    chk("tie2_grant_c0_data", {dut_a_data, dut_b_data}, 2'b10);
    chk("tie2_c1_waiting", c1_req_rdy, 0);
    step(); step();
    chk("tie2_c0_resp", {c0_resp_rdy, c0_resp_data}, 2'b11);
    c0_resp_en = 1; step(); c0_resp_en = 0;
    step(); step();
    chk("tie2_c1_resp", {c1_resp_rdy, c1_resp_data}, 2'b10);
    c1_resp_en = 1; step(); c1_resp_en = 0;

    // Backpressure on operand b for three SEND cycles
    dut_b_rdy = 0;
    c0_req_a = 0; c0_req_b = 1; c0_req_en = 1;
    step(); c0_req_en = 0;
    step();
    chk("bp_cyc1_ens", {dut_a_en, dut_b_en}, 2'b10);
    step();
    chk("bp_cyc2_ens", {dut_a_en, dut_b_en, dut_y_en}, 3'b000);
    chk("bp_cyc2_bdata", dut_b_data, 1);
    step();
    chk("bp_cyc3_ens", {dut_a_en, dut_b_en, dut_y_en}, 3'b000);
    dut_b_rdy = 1; #1;
    chk("bp_b_fires", {dut_a_en, dut_b_en}, 2'b01);
    step();
    chk("bp_wait_y", {dut_a_en, dut_b_en, dut_y_en}, 3'b001);
    step();
    chk("bp_resp", {c0_resp_rdy, c0_resp_data}, 2'b11);
    c0_resp_en = 1; step(); c0_resp_en = 0;

    // Undrained result blocks c0, c1 proceeds
    c0_req_a = 1; c0_req_b = 1; c0_req_en = 1;
    step(); c0_req_en = 0;
    step(); step(); step();
    chk("undr_c0_first", {c0_resp_rdy, c0_resp_data}, 2'b11);
    c0_req_a = 0; c0_req_b = 1; c0_req_en = 1;
    c1_req_a = 1; c1_req_b = 0; c1_req_en = 1;
    step(); c0_req_en = 0; c1_req_en = 0;
    step();
    chk("undr_grant_c1", {dut_a_data, dut_b_data}, 2'b10);
    chk("undr_c0_held", {c0_req_rdy, c1_req_rdy}, 2'b01);
    step(); step();
    chk("undr_c1_resp", {c1_resp_rdy, c1_resp_data, c0_resp_rdy}, 3'b111);
    step();
    chk("undr_no_grant", {dut_a_en, c0_req_rdy}, 2'b00);
    c0_resp_en = 1; c1_resp_en = 1;
    step(); c0_resp_en = 0; c1_resp_en = 0;
    chk("undr_drain_cycle_idle", {c0_resp_rdy, dut_a_en, dut_a_data}, 3'b000);
    step();
    chk("undr_grant_c0", {dut_a_data, dut_b_data, dut_a_en, c0_req_rdy}, 4'b0111);
    step(); step();
    chk("undr_c0_resp", {c0_resp_rdy, c0_resp_data}, 2'b11);
    c0_resp_en = 1; step(); c0_resp_en = 0;

    // Reset while waiting for the result; fire during reset is ignored
    dut_y_rdy = 0;
    c1_req_a = 1; c1_req_b = 0; c1_req_en = 1;
    step(); c1_req_en = 0;
    step(); step();
    chk("rst_wait_y_stalled", {dut_y_en, c1_resp_rdy}, 2'b00);
    RST = 1; c0_req_a = 1; c0_req_b = 1; c0_req_en = 1;
    step();
    RST = 0; c0_req_en = 0; dut_y_rdy = 1;
    chk_reset_vals("midrst");
    step(); step(); step(); step();
    chk("midrst_no_resp", {c0_resp_rdy, c1_resp_rdy, dut_a_en, dut_y_en}, 4'b0000);

    // Streaming with random shared-unit readiness
    sent0 = 0; sent1 = 0; got0 = 0; got1 = 0;
    for (int cyc = 0; cyc < 3000 && (got0 < 8 || got1 < 8); cyc++) begin
      c0_req_en = 0; c1_req_en = 0; c0_resp_en = 0; c1_resp_en = 0;
      dut_a_rdy = 1'($urandom_range(0, 1));
      dut_b_rdy = 1'($urandom_range(0, 1));
      dut_y_rdy = 1'($urandom_range(0, 1));
      if (c0_req_rdy && sent0 < 8 && $urandom_range(0, 1) == 1) begin
        c0_req_a = 1'($urandom_range(0, 1)); c0_req_b = 1'($urandom_range(0, 1));
        c0_req_en = 1; q0.push_back(c0_req_a | c0_req_b); sent0++;
      end
      if (c1_req_rdy && sent1 < 8 && $urandom_range(0, 1) == 1) begin
        c1_req_a = 1'($urandom_range(0, 1)); c1_req_b = 1'($urandom_range(0, 1));
        c1_req_en = 1; q1.push_back(c1_req_a | c1_req_b); sent1++;
      end
      if (c0_resp_rdy && $urandom_range(0, 1) == 1) begin
        c0_resp_en = 1;
        exp = (q0.size() > 0) ? 8'(q0.pop_front()) : 8'h2;
        chk("stream_c0_data", c0_resp_data, exp); got0++;
      end
      if (c1_resp_rdy && $urandom_range(0, 1) == 1) begin
        c1_resp_en = 1;
        exp = (q1.size() > 0) ? 8'(q1.pop_front()) : 8'h2;
        chk("stream_c1_data", c1_resp_data, exp); got1++;
      end
      #1;
      chk("stream_en_without_rdy",
          {dut_a_en & ~dut_a_rdy, dut_b_en & ~dut_b_rdy, dut_y_en & ~dut_y_rdy}, 0);
      step();
    end
    c0_req_en = 0; c1_req_en = 0; c0_resp_en = 0; c1_resp_en = 0;
    chk("stream_all_delivered", 8'(got0 + got1), 8'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
